// File: rtl/alu_pe_sched.sv
// Credit-based round-robin issue scheduler for the INT/MULDIV/DOT8 PEs of one ALU block.
// Optional starvation (age) priority is enabled with `define ALU_SCHED_AGE_PRIO_EN.
module alu_pe_sched #(
    parameter int NUM_REQS     = 4,
    parameter int PE_COUNT     = 3,
    parameter int CREDITS      = 4,
    parameter int STARVE_LIMIT = 15,
    localparam int PSW = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1,
    localparam int RSW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int CW  = $clog2(CREDITS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQS-1:0]     req_valid,
    input  logic [NUM_REQS*PSW-1:0] req_pe_sel,
    output logic [NUM_REQS-1:0]     req_ready,
    output logic                    out_valid,
    output logic [RSW-1:0]          out_req_idx,
    output logic [PSW-1:0]          out_pe_sel,
    input  logic                    out_ready,
    input  logic [PE_COUNT-1:0]     rsp_done,
    output logic [PE_COUNT*CW-1:0]  credit_cnt,
    output logic                    credit_err
);

    localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

    logic [CW-1:0]       credit_reg [PE_COUNT];
    logic [(1<<PSW)-1:0] pe_has_credit;
    logic [NUM_REQS-1:0] elig;
    logic [PE_COUNT-1:0] pe_dec;
    logic [PE_COUNT-1:0] err_hit;
    logic [RSW-1:0]      rr_ptr_reg;
    logic [RSW-1:0]      rr_win;
    logic                rr_found;
    logic [RSW-1:0]      win;
    logic                win_found;
    logic [PSW-1:0]      win_pe;
    logic                stage_free;
    logic                grant;
    logic                out_valid_reg;
    logic [RSW-1:0]      out_req_idx_reg;
    logic [PSW-1:0]      out_pe_sel_reg;
    logic                credit_err_reg;

    // Out-of-range PE codes map to padding entries that never have credit.
    genvar gi;
    generate
        for (gi = 0; gi < (1 << PSW); gi++) begin : g_pe_credit
            if (gi < PE_COUNT) begin : g_real
                assign pe_has_credit[gi] = (credit_reg[gi] != '0);
            end else begin : g_pad
                assign pe_has_credit[gi] = 1'b0;
            end
        end
        for (gi = 0; gi < NUM_REQS; gi++) begin : g_elig
            assign elig[gi] = req_valid[gi] && pe_has_credit[req_pe_sel[gi*PSW +: PSW]];
        end
        for (gi = 0; gi < PE_COUNT; gi++) begin : g_credit_out
            assign pe_dec[gi]  = grant && (win_pe == PSW'(gi));
            assign err_hit[gi] = rsp_done[gi] && (credit_reg[gi] == CREDIT_MAX);
            assign credit_cnt[gi*CW +: CW] = credit_reg[gi];
        end
    endgenerate

    always_comb begin
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_win   = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_REQS;
            if (!rr_found && elig[idx]) begin
                rr_found = 1'b1;
                rr_win   = RSW'(idx);
            end
        end
    end

`ifdef ALU_SCHED_AGE_PRIO_EN
    localparam int AW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW-1:0] STARVE_MAX = AW'(STARVE_LIMIT);

    logic [AW-1:0] age_reg [NUM_REQS];
    logic [RSW-1:0] old_win;
    logic           old_found;

    // Starved requesters override round-robin, lowest index first.
    always_comb begin
        old_found = 1'b0;
        old_win   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!old_found && elig[i] && (age_reg[i] >= STARVE_MAX)) begin
                old_found = 1'b1;
                old_win   = RSW'(i);
            end
        end
        win_found = old_found || rr_found;
        win       = old_found ? old_win : rr_win;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQS; i++) age_reg[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (!req_valid[i] || req_ready[i])
                    age_reg[i] <= '0;
                else if (age_reg[i] != STARVE_MAX)
                    age_reg[i] <= age_reg[i] + 1'b1;
            end
        end
    end
`else
    always_comb begin
        win_found = rr_found;
        win       = rr_win;
    end
`endif

    assign stage_free = !out_valid_reg || out_ready;
    assign grant      = stage_free && win_found;
    assign win_pe     = req_pe_sel[int'(win)*PSW +: PSW];

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg   <= 1'b0;
            out_req_idx_reg <= '0;
            out_pe_sel_reg  <= '0;
            rr_ptr_reg      <= '0;
        end else if (grant) begin
            out_valid_reg   <= 1'b1;
            out_req_idx_reg <= win;
            out_pe_sel_reg  <= win_pe;
            rr_ptr_reg      <= RSW'((int'(win) + 1) % NUM_REQS);
        end else if (out_ready) begin
            out_valid_reg   <= 1'b0;
        end
    end

    // A return at full count is a protocol error: the count holds, the flag sticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < PE_COUNT; p++) credit_reg[p] <= CREDIT_MAX;
            credit_err_reg <= 1'b0;
        end else begin
            for (int p = 0; p < PE_COUNT; p++) begin
                if (rsp_done[p] && !pe_dec[p] && (credit_reg[p] != CREDIT_MAX))
                    credit_reg[p] <= credit_reg[p] + 1'b1;
                else if (pe_dec[p] && !rsp_done[p])
                    credit_reg[p] <= credit_reg[p] - 1'b1;
            end
            if (|err_hit) credit_err_reg <= 1'b1;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_req_idx = out_req_idx_reg;
    assign out_pe_sel  = out_pe_sel_reg;
    assign credit_err  = credit_err_reg;

endmodule

// File: tb/tb_alu_pe_sched.sv
// Randomized + directed bench for alu_pe_sched against a cycle-level reference model.
module tb_alu_pe_sched;

    localparam int N   = 4;
    localparam int P   = 3;
    localparam int C   = 4;
    localparam int PSW = 2;
    localparam int RSW = 2;
    localparam int CW  = 3;
`ifdef ALU_SCHED_AGE_PRIO_EN
    localparam int STARVE = 3;
`else
    localparam int STARVE = 15;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*PSW-1:0]  req_pe_sel = '0;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [RSW-1:0]    out_req_idx;
    logic [PSW-1:0]    out_pe_sel;
    logic              out_ready = 1'b0;
    logic [P-1:0]      rsp_done = '0;
    logic [P*CW-1:0]   credit_cnt;
    logic              credit_err;

    alu_pe_sched #(
        .NUM_REQS(N), .PE_COUNT(P), .CREDITS(C), .STARVE_LIMIT(STARVE)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_pe_sel(req_pe_sel), .req_ready(req_ready),
        .out_valid(out_valid), .out_req_idx(out_req_idx), .out_pe_sel(out_pe_sel),
        .out_ready(out_ready), .rsp_done(rsp_done),
        .credit_cnt(credit_cnt), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: plain integers describing the scheduler's observable behaviour.
    int m_cred [P];
    int m_age  [N];
    int m_rr;
    int m_ov, m_idx, m_pe, m_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [P*CW-1:0] model_credits();
        logic [P*CW-1:0] v;
        v = '0;
        for (int p = 0; p < P; p++) v[p*CW +: CW] = CW'(m_cred[p]);
        return v;
    endfunction

    function automatic logic [N*PSW-1:0] all_pe(input int p);
        logic [N*PSW-1:0] v;
        for (int i = 0; i < N; i++) v[i*PSW +: PSW] = PSW'(p);
        return v;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < P; p++) m_cred[p] = C;
        for (int i = 0; i < N; i++) m_age[i] = 0;
        m_rr = 0; m_ov = 0; m_idx = 0; m_pe = 0; m_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        req_valid = '0; req_pe_sel = '0; out_ready = 1'b0; rsp_done = '0;
        model_reset();
        #1;
        check_val("rst_out_valid", 32'(out_valid), 0);
        check_val("rst_out_idx", 32'(out_req_idx), 0);
        check_val("rst_out_pe", 32'(out_pe_sel), 0);
        check_val("rst_credits", 32'(credit_cnt), 32'(model_credits()));
        check_val("rst_credit_err", 32'(credit_err), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("idle_req_ready", 32'(req_ready), 0);
    endtask

    // One clock of stimulus: predicts the grant, checks it, then checks registered outputs.
    task automatic step(input logic [N-1:0] v, input logic [N*PSW-1:0] s,
                        input logic ordy, input logic [P-1:0] done);
        int w, sel_i, wpe;
        bit found, grant;
        bit elig [N];
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        req_valid = v; req_pe_sel = s; out_ready = ordy; rsp_done = done;
        #1;
        found = 0; w = 0;
        for (int i = 0; i < N; i++) begin
            sel_i = int'(s[i*PSW +: PSW]);
            elig[i] = v[i] && (sel_i < P) && (m_cred[sel_i % P] > 0);
        end
`ifdef ALU_SCHED_AGE_PRIO_EN
        for (int i = 0; i < N; i++)
            if (!found && elig[i] && m_age[i] >= STARVE) begin found = 1; w = i; end
`endif
        for (int k = 0; k < N; k++)
            if (!found && elig[(m_rr + k) % N]) begin found = 1; w = (m_rr + k) % N; end
        grant = found && (m_ov == 0 || ordy);
        exp_rdy = '0;
        if (grant) exp_rdy[w] = 1'b1;
        check_val("req_ready", 32'(req_ready), 32'(exp_rdy));

        @(posedge clk);
        wpe = int'(s[w*PSW +: PSW]);
        for (int p = 0; p < P; p++) begin
            if (done[p] && m_cred[p] == C) m_err = 1;
            if (done[p] && !(grant && wpe == p) && m_cred[p] < C) m_cred[p]++;
            else if (!done[p] && grant && wpe == p) m_cred[p]--;
        end
        for (int i = 0; i < N; i++) begin
            if (!v[i] || exp_rdy[i]) m_age[i] = 0;
            else if (m_age[i] < STARVE) m_age[i]++;
        end
        if (grant) begin
            m_ov = 1; m_idx = w; m_pe = wpe; m_rr = (w + 1) % N;
        end else if (ordy) begin
            m_ov = 0;
        end
        #1;
        check_val("out_valid", 32'(out_valid), 32'(m_ov));
        check_val("out_req_idx", 32'(out_req_idx), 32'(m_idx));
        check_val("out_pe_sel", 32'(out_pe_sel), 32'(m_pe));
        check_val("credit_cnt", 32'(credit_cnt), 32'(model_credits()));
        check_val("credit_err", 32'(credit_err), 32'(m_err));
    endtask

    initial begin
        logic [N-1:0]     rv;
        logic [N*PSW-1:0] rs;
        logic [P-1:0]     rd;
        logic             ro;

        model_reset();
        do_reset();

        // Round-robin: everyone to PE0, PE0 returns a credit each cycle from cycle 2.
        for (int k = 0; k < 6; k++)
            step(4'b1111, all_pe(0), 1'b1, (k >= 2) ? 3'b001 : 3'b000);
        step('0, all_pe(0), 1'b1, 3'b001);
        step('0, all_pe(0), 1'b1, 3'b001);

        // Credit exhaustion on PE1, then a single return.
        for (int k = 0; k < 6; k++) step(4'b0001, all_pe(1), 1'b1, 3'b000);
        check_val("pe1_empty", 32'(credit_cnt[1*CW +: CW]), 0);
        step(4'b0001, all_pe(1), 1'b1, 3'b010);
        step(4'b0001, all_pe(1), 1'b1, 3'b000);
        step(4'b0001, all_pe(1), 1'b1, 3'b000);

        // Backpressure on PE2 traffic, then release.
        step(4'b0011, all_pe(2), 1'b1, 3'b000);
        for (int k = 0; k < 3; k++) step(4'b0011, all_pe(2), 1'b0, 3'b000);
        step(4'b0011, all_pe(2), 1'b1, 3'b000);

        // Grant to PE2 and a PE2 return in the same cycle.
        step(4'b0100, all_pe(2), 1'b1, 3'b100);
        step('0, all_pe(2), 1'b1, 3'b000);

        // Reset mid-operation, then legal random traffic.
        do_reset();
        for (int k = 0; k < 500; k++) begin
            rv = N'($urandom);
            for (int i = 0; i < N; i++) rs[i*PSW +: PSW] = PSW'($urandom_range(0, P - 1));
            ro = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < P; p++) rd[p] = (m_cred[p] < C) && ($urandom_range(0, 2) == 0);
            step(rv, rs, ro, rd);
        end

        // Return into a full PE0 must flag an error and leave the count alone.
        do_reset();
        step('0, all_pe(0), 1'b1, 3'b001);
        check_val("err_sticky", 32'(credit_err), 1);
        check_val("pe0_full", 32'(credit_cnt[0 +: CW]), 32'(C));
        step('0, all_pe(0), 1'b1, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
